// File: rtl/cs_add_if.sv
// Valid/ready request and result bundle for the chunked carry-select add sequencer.
// The master side is the requester/consumer. The slave side is the sequencer.
interface cs_add_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/cs_add_sequencer.sv
// Multi-cycle add/subtract controller. One CHUNK-wide carry-select slice is time-shared
// across the WIDTH-bit operands, LSB chunk first, with the running carry as slice select.
module cs_add_sequencer #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic    clk,
  input  logic    rst,
  cs_add_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = $clog2(NCH);
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

  if (((WIDTH % CHUNK) != 0) || (NCH < 2)) begin : g_bad_params
    $error("cs_add_sequencer: WIDTH must be a multiple of CHUNK with at least two chunks");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Both candidate sums are formed, and the incoming carry picks one.
  function automatic logic [CHUNK:0] cs_slice(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             sel);
    logic [CHUNK:0] r0;
    logic [CHUNK:0] r1;
    r0 = {1'b0, x} + {1'b0, y};
    r1 = {1'b0, x} + {1'b0, y} + (CHUNK+1)'(1);
    return sel ? r1 : r0;
  endfunction

  state_t           state;
  logic [KW-1:0]    k;
  logic             carry;
  logic             rdy_en;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             in_ready_c;
  logic             accept;

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;

  logic [CHUNK-1:0] sa_p1;
  logic [CHUNK-1:0] sb_p1;
  logic [CHUNK:0]   slice_p1;
  logic             ovf_p1;

  assign in_ready_c = rdy_en & ((state == IDLE) | ((state == DONE) & bus.out_ready));
  assign accept     = bus.in_valid & in_ready_c;

  // Operand capture stage: data only, loaded on acceptance with B pre-inverted for subtract.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= bus.a;
      b_p0 <= bus.sub ? ~bus.b : bus.b;
    end
  end

  // Slice stage: the active chunk through the shared slice.
  // Overflow recovers the carry into the MSB from the inputs and the sum MSB.
  assign sa_p1    = a_p0[k*CHUNK +: CHUNK];
  assign sb_p1    = b_p0[k*CHUNK +: CHUNK];
  assign slice_p1 = cs_slice(sa_p1, sb_p1, carry);
  assign ovf_p1   = (sa_p1[CHUNK-1] ^ sb_p1[CHUNK-1] ^ slice_p1[CHUNK-1]) ^ slice_p1[CHUNK];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      carry       <= 1'b0;
      rdy_en      <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= RUN;
            busy_r <= 1'b1;
            k      <= '0;
            carry  <= bus.sub | bus.cin;
          end
        end
        RUN: begin
          sum_r[k*CHUNK +: CHUNK] <= slice_p1[CHUNK-1:0];
          carry                   <= slice_p1[CHUNK];
          if (k == K_LAST) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            cout_r      <= slice_p1[CHUNK];
            ovf_r       <= ovf_p1;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (accept) begin
              state <= RUN;
              k     <= '0;
              carry <= bus.sub | bus.cin;
            end else begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_cs_add_sequencer.sv
// Directed and randomized bench for cs_add_sequencer (WIDTH=16, CHUNK=4) with an
// arithmetic reference model and an in-order expected-result queue.
module tb_cs_add_sequencer;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int NCH   = WIDTH / CHUNK;
  localparam int NRAND = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cs_add_if #(.WIDTH(WIDTH)) bus();

  cs_add_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from plain signed/unsigned arithmetic.
  function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci, input logic s);
    int          sx;
    int          sy;
    int          r;
    logic [15:0] res;
    logic        co;
    sx = $signed(x);
    sy = $signed(y);
    if (s) begin
      r   = sx - sy;
      res = x - y;
      co  = (x >= y);
    end else begin
      r          = sx + sy + int'(ci);
      {co, res}  = {1'b0, x} + {1'b0, y} + 17'(ci);
    end
    return {((r > 32767) || (r < -32768)), co, res};
  endfunction

  function automatic logic [17:0] dut_result();
    return {bus.ovf, bus.cout, bus.sum};
  endfunction

  // Drives a request and returns at #1 after the accepting edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic s);
    int w;
    w = 0;
    bus.a = x; bus.b = y; bus.cin = ci; bus.sub = s; bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("send_ready_timeout", 32'(w < 50), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom);
    bus.cin = 1'($urandom); bus.sub = 1'($urandom);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  logic [17:0] exp_q[$];
  logic [17:0] hold_v;
  logic [17:0] e;
  logic        acc_in;
  logic        acc_out;
  int          c;
  int          sent;
  int          got;
  int          cyc;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("busy_run", 32'(bus.busy), 32'd1);
    wait_out(c);
    check("lat_ffff", 32'(c), 32'(NCH));
    check("res_ffff", 32'(dut_result()), 32'h10000);
    check("in_ready_done_stalled", 32'(bus.in_ready), 32'd0);
    drain();
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_out(c);
    check("lat_7fff", 32'(c), 32'(NCH));
    check("res_7fff", 32'(dut_result()), 32'h28000);
    drain();

    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_out(c);
    check("res_5m7", 32'(dut_result()), 32'h0FFFE);
    drain();

    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_out(c);
    check("res_8000m1", 32'(dut_result()), 32'h37FFF);
    drain();

    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_out(c);
    check("res_stall", 32'(dut_result()), 32'h05555);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_vals", 32'(dut_result()), 32'h05555);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.a = 16'h0F0F; bus.b = 16'h00F1; bus.cin = 1'b1; bus.sub = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = 16'hDEAD; bus.b = 16'hBEEF;
    check("b2b_out_valid_drop", 32'(bus.out_valid), 32'd0);
    wait_out(c);
    check("lat_b2b", 32'(c), 32'(NCH));
    check("res_b2b", 32'(dut_result()), 32'(ref_model(16'h0F0F, 16'h00F1, 1'b1, 1'b0)));
    drain();

    send(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_sum", 32'(bus.sum), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_out(c);
    check("res_after_rst", 32'(bus.sum), 32'h2345);
    drain();

    sent = 0; got = 0; cyc = 0;
    while (got < NRAND && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      acc_out = bus.out_valid & bus.out_ready;
      acc_in  = bus.in_valid & bus.in_ready;
      if (acc_out) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rand_result", 32'(dut_result()), 32'(e));
        end
        got++;
      end
      if (acc_in) begin
        exp_q.push_back(ref_model(bus.a, bus.b, bus.cin, bus.sub));
        sent++;
      end
      @(posedge clk); #1;
      if (acc_in) bus.in_valid = 1'b0;
      if (!bus.in_valid && sent < NRAND && $urandom_range(0, 3) != 0) begin
        bus.a = 16'($urandom); bus.b = 16'($urandom);
        bus.cin = 1'($urandom); bus.sub = 1'($urandom);
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
    check("rand_count", 32'(got), 32'(NRAND));
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
